spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI target (mode 0: CPOL=0, CPHA=0, 8-bit frames, MSB first) for the
//  far end of the spi_master link. Oversamples SPI pins with the local
//  system clock. Received bytes go out on a put/full push port; bytes to
//  send come in on a get/empty pop port (first-word-fall-through source).
//  Sits between SPI pads and byte FIFOs; clock must be >= 8x SPI bit rate.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser depth for spi_cs_n/spi_clock/spi_mosi (>=2)
//  IDLE_BYTE    8'hFF  byte shifted out when no TX byte is pending (underrun)
// PORTS
//  reset        in   1  asynchronous, active-high
//  clock        in   1  system clock, rising edge
//  out          out  8  received byte, valid when put=1
//  put          out  1  one-cycle push strobe
//  full         in   1  sink full; byte dropped if set at push time
//  in           in   8  TX byte from source, valid while empty=0
//  get          out  1  one-cycle pop strobe to source
//  empty        in   1  source empty
//  spi_cs_n     in   1  chip select, active low, async to clock
//  spi_clock    in   1  SPI clock, async to clock
//  spi_mosi     in   1  master-out data
//  spi_miso     out  1  slave-out data (registered)
//  spi_miso_oe  out  1  pad output enable = synchronised !spi_cs_n
//  busy         out  1  frame in progress (synchronised select active)
// BEHAVIOUR
//  - Reset: out=0, put=0, get=0, spi_miso=1, spi_miso_oe=0, busy=0, bit
//    count=0, pending-TX flag=0, sync chains=idle (cs_n=1, clock=0).
//  - Pins pass SYNC_STAGES flops plus one history flop; edges = cur vs prev.
//  - TX prefetch: on edge where !avail & !empty & !get: data<=in, avail<=1,
//    get<=1. get is high exactly one cycle; source pops on that edge.
//  - Select fall (sync): cnt<=0, busy<=1, oe<=1; load shifter from data
//    (avail<=0) or IDLE_BYTE if !avail; spi_miso<=shifter MSB.
//  - spi_clock rise (busy): rx<={rx[6:0],mosi}; cnt<=cnt+1 (3-bit wrap).
//    On cnt 7->0: out<=completed byte, put<=!full (1 cycle); if full the
//    byte is dropped, no retry.
//  - spi_clock fall (busy): if cnt==0 reload shifter (data or IDLE_BYTE,
//    clearing avail) and drive new MSB; else shift, drive next bit.
//  - Select rise (sync): busy<=0, oe<=0, spi_miso<=1, cnt<=0; partial RX
//    bits discarded, no put; partially sent byte lost; pending data kept.
//  - Prefetch and a reload on the same edge: reload takes data, avail<=0;
//    new prefetch only on a later cycle.
//  - SPI edges with select inactive are ignored.
//  - Latency: put 1 clock after the synchronised 8th rising edge, i.e.
//    SYNC_STAGES+1..SYNC_STAGES+2 clocks after the pin edge.
// CONFIGURATION
//  SPI_SLAVE_LSB_FIRST_EN defined: LSB first both directions (rx shifts in
//  at bit 7 rightwards, tx emits bit 0 first). Undefined: MSB first as
//  above. Framing, handshakes and timing identical either way.
// TESTING
//  - Reset mid-frame: assert reset during bit 4 -> all outputs at reset
//    values next cycle, no put; after release next full frame works.
//  - Source holds 8'hA5, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1;
//    one put with out=8'h3C; get pulsed exactly once before the frame.
//  - Empty source, master sends 8'h00 twice -> miso all ones (IDLE_BYTE);
//    two puts, out=8'h00 each; get never asserted.
//  - Back-to-back 3 bytes, source 8'h01,8'h02,8'h03 -> miso sequence
//    matches with no gap; three puts in order matching mosi bytes.
//  - full=1 during byte 2 of 3 -> puts only for bytes 1 and 3; byte 2
//    lost; TX unaffected.
//  - spi_cs_n rises after 5 bits -> no put, cnt=0, oe=0, miso=1; next
//    frame delivers a correct full byte.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 target: oversampled pins, byte push/pop ports.
// Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first in both directions.
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       reset,
    input  logic       clock,
    output logic [7:0] out,
    output logic       put,
    input  logic       full,
    input  logic [7:0] in,
    output logic       get,
    input  logic       empty,
    input  logic       spi_cs_n,
    input  logic       spi_clock,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       busy
);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic cs_prev;
    logic clk_prev;

    logic cs_cur;
    logic clk_cur;
    logic mosi_cur;
    logic sel_fall;
    logic sel_rise;
    logic clk_rise;
    logic clk_fall;

    logic [7:0] data;
    logic       avail;
    logic [7:0] shifter;
    logic [6:0] rx;
    logic [2:0] cnt;

    logic [7:0] load_byte;
    logic       load_first;
    logic [7:0] shift_nxt;
    logic       shift_bit;
    logic [7:0] rx_nxt;
    logic       reload;
    logic       take;

    assign cs_cur   = cs_sync[SYNC_STAGES-1];
    assign clk_cur  = clk_sync[SYNC_STAGES-1];
    assign mosi_cur = mosi_sync[SYNC_STAGES-1];

    assign sel_fall = cs_prev & ~cs_cur;
    assign sel_rise = ~cs_prev & cs_cur;
    assign clk_rise = ~clk_prev & clk_cur;
    assign clk_fall = clk_prev & ~clk_cur;

    // Underrun sends the idle pattern instead of stale data.
    assign load_byte = avail ? data : IDLE_BYTE;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign load_first = load_byte[0];
    assign shift_nxt  = {shifter[0], shifter[7:1]};
    assign shift_bit  = shift_nxt[0];
    assign rx_nxt     = {mosi_cur, rx};
`else
    assign load_first = load_byte[7];
    assign shift_nxt  = {shifter[6:0], shifter[7]};
    assign shift_bit  = shift_nxt[7];
    assign rx_nxt     = {rx, mosi_cur};
`endif

    // Reload points: frame start and every byte boundary on the falling edge.
    assign reload = ((state == S_IDLE) && sel_fall) ||
                    ((state == S_ACTIVE) && !sel_rise &&
                     clk_fall && (cnt == 3'd0));

    // A reload owns the data register this cycle; prefetch waits a cycle.
    assign take = !avail && !empty && !get && !reload;

    // Pin synchronisers plus one history flop for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            clk_sync  <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            clk_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clock};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_prev   <= cs_cur;
            clk_prev  <= clk_cur;
        end
    end

    // Frame FSM with TX prefetch, shifting and registered pad outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            out         <= 8'h00;
            put         <= 1'b0;
            get         <= 1'b0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
            data        <= 8'h00;
            avail       <= 1'b0;
            shifter     <= 8'h00;
            rx          <= 7'h00;
            cnt         <= 3'd0;
        end else begin
            put <= 1'b0;
            get <= take;
            if (take) begin
                data  <= in;
                avail <= 1'b1;
            end
            if (reload && avail) begin
                avail <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (sel_fall) begin
                        state       <= S_ACTIVE;
                        busy        <= 1'b1;
                        spi_miso_oe <= 1'b1;
                        cnt         <= 3'd0;
                        shifter     <= load_byte;
                        spi_miso    <= load_first;
                    end
                end
                S_ACTIVE: begin
                    if (sel_rise) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        spi_miso_oe <= 1'b0;
                        spi_miso    <= 1'b1;
                        cnt         <= 3'd0;
                    end else if (clk_rise) begin
                        rx  <= rx_nxt[6:0];
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            out <= rx_nxt;
                            put <= !full;
                        end
                    end else if (clk_fall) begin
                        if (cnt == 3'd0) begin
                            shifter  <= load_byte;
                            spi_miso <= load_first;
                        end else begin
                            shifter  <= shift_nxt;
                            spi_miso <= shift_bit;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave with a byte-slot reference model.
// Byte order follows SPI_SLAVE_LSB_FIRST_EN when defined.
module tb_spi_slave;

    localparam int H = 80;
    localparam logic [7:0] IDLE = 8'hFF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] out;
    logic       put;
    logic       full = 1'b0;
    logic [7:0] src_in = 8'h00;
    logic       get;
    logic       src_empty = 1'b1;
    logic       spi_cs_n = 1'b1;
    logic       spi_clock = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_get = 0;

    logic [7:0] got[$];
    logic [7:0] src_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] m_bytes[0:3];

    spi_slave dut (
        .reset      (reset),
        .clock      (clock),
        .out        (out),
        .put        (put),
        .full       (full),
        .in         (src_in),
        .get        (get),
        .empty      (src_empty),
        .spi_cs_n   (spi_cs_n),
        .spi_clock  (spi_clock),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (put) got.push_back(out);
        if (get) n_get++;
        src_empty = (src_q.size() == 0);
        src_in = src_empty ? 8'h00 : src_q[0];
    end

    always @(posedge clock) begin
        if (get && src_q.size() > 0) void'(src_q.pop_front());
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int bpos(input int k);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return k;
`else
        return 7 - k;
`endif
    endfunction

    function automatic logic [7:0] next_tx();
        if (exp_tx.size() > 0) return exp_tx.pop_front();
        return IDLE;
    endfunction

    task automatic src_push(input logic [7:0] v);
        @(negedge clock);
        src_q.push_back(v);
        exp_tx.push_back(v);
    endtask

    task automatic check_reset_outs();
        chk("rst_out", out, 8'h00);
        chk("rst_put", put, 1'b0);
        chk("rst_get", get, 1'b0);
        chk("rst_miso", spi_miso, 1'b1);
        chk("rst_oe", spi_miso_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
    endtask

    task automatic run_frame(input int nbytes, input int abort_bits,
                             input int full_byte);
        logic [7:0] want;
        logic [7:0] seen;
        int bits;
        spi_cs_n = 1'b0;
        want = next_tx();
        for (int b = 0; b < nbytes; b++) begin
            full = (b == full_byte);
            bits = (abort_bits > 0 && b == nbytes - 1) ? abort_bits : 8;
            seen = 8'h00;
            for (int k = 0; k < bits; k++) begin
                spi_mosi = m_bytes[b][bpos(k)];
                #H;
                seen[bpos(k)] = spi_miso;
                if (b == 0 && k == 1) begin
                    chk("busy_on", busy, 1'b1);
                    chk("oe_on", spi_miso_oe, 1'b1);
                end
                spi_clock = 1'b1;
                #H;
                spi_clock = 1'b0;
            end
            if (bits == 8) begin
                chk("miso", seen, want);
                want = next_tx();
                if (!full) exp_rx.push_back(m_bytes[b]);
            end
        end
        #H;
        spi_cs_n = 1'b1;
        full = 1'b0;
        #(4 * H);
    endtask

    task automatic check_rx();
        repeat (8) @(negedge clock);
        chk("nput", got.size(), exp_rx.size());
        for (int i = 0; i < got.size() && i < exp_rx.size(); i++)
            chk("rx", got[i], exp_rx[i]);
        got.delete();
        exp_rx.delete();
    endtask

    initial begin
        int g0;
        int nb;
        int fb;
        int ab;
        int np;

        repeat (3) @(negedge clock);
        check_reset_outs();
        reset = 1'b0;
        repeat (4) @(negedge clock);

        g0 = n_get;
        src_push(8'hA5);
        repeat (10) @(negedge clock);
        chk("get_once", n_get - g0, 1);
        m_bytes[0] = 8'h3C;
        run_frame(1, 0, -1);
        check_rx();
        chk("get_total", n_get - g0, 1);

        g0 = n_get;
        m_bytes[0] = 8'h00;
        run_frame(1, 0, -1);
        run_frame(1, 0, -1);
        check_rx();
        chk("get_none", n_get - g0, 0);

        src_push(8'h01);
        src_push(8'h02);
        src_push(8'h03);
        repeat (4) @(negedge clock);
        m_bytes[0] = 8'h81;
        m_bytes[1] = 8'h42;
        m_bytes[2] = 8'hE7;
        run_frame(3, 0, -1);
        check_rx();

        src_push(8'h11);
        src_push(8'h22);
        src_push(8'h33);
        repeat (4) @(negedge clock);
        m_bytes[0] = 8'h5A;
        m_bytes[1] = 8'hC3;
        m_bytes[2] = 8'h96;
        run_frame(3, 0, 1);
        check_rx();

        src_push(8'hAA);
        src_push(8'h55);
        repeat (4) @(negedge clock);
        m_bytes[0] = 8'hF0;
        run_frame(1, 5, -1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_oe", spi_miso_oe, 1'b0);
        chk("abort_miso", spi_miso, 1'b1);
        check_rx();
        m_bytes[0] = 8'h69;
        run_frame(1, 0, -1);
        check_rx();

        spi_cs_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            spi_mosi = 1'b1;
            #H;
            spi_clock = 1'b1;
            #H;
            spi_clock = 1'b0;
        end
        spi_mosi = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outs();
        spi_cs_n = 1'b1;
        spi_clock = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_rx();
        src_push(8'hC9);
        repeat (4) @(negedge clock);
        m_bytes[0] = 8'h27;
        run_frame(1, 0, -1);
        check_rx();

        for (int it = 0; it < 10; it++) begin
            np = $urandom_range(0, 3);
            for (int i = 0; i < np; i++) src_push(8'($urandom));
            repeat (4) @(negedge clock);
            nb = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) m_bytes[i] = 8'($urandom);
            fb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            run_frame(nb, ab, fb);
            check_rx();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
